// File: rtl/adc733_frame_buffer.sv
// adc733_frame_buffer
//   Receives 16-bit ADC words from the adc733 serial front end. It checks frame
//   alignment against the frame-start marker, tags each word with its channel
//   index, and buffers the result in a synchronous FIFO for readout.
//
//   Ports:
//     clk, rst              system clock, async active-high reset
//     word_valid/word_data  one-cycle sample strobe plus 16-bit sample
//     frame_start           qualifies word_valid: this word is channel 0
//     rd_en                 pop request (ignored while empty)
//     rd_data/rd_ch         registered popped sample and its channel index
//     rd_valid              rd_data/rd_ch updated this cycle (pop latency 1)
//     empty/full/level      registered FIFO status, level in 0..DEPTH
//     overrun/frame_err     sticky error flags
//     clr_err               synchronous clear of the sticky flags
//
//   Optional build macro ADC733_FB_FRAME_CNT_EN adds an 8-bit frame counter.
//   The counter is stored with every entry and returned on rd_frame.
module adc733_frame_buffer #(
  parameter int NUM_CH = 6,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          word_valid,
  input  logic [15:0]   word_data,
  input  logic          frame_start,
  input  logic          rd_en,
  output logic [15:0]   rd_data,
  output logic [2:0]    rd_ch,
`ifdef ADC733_FB_FRAME_CNT_EN
  output logic [7:0]    rd_frame,
`endif
  output logic          rd_valid,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  output logic          overrun,
  output logic          frame_err,
  input  logic          clr_err
);

  typedef enum logic {UNSYNC = 1'b0, SYNC = 1'b1} state_t;

  typedef struct packed {
`ifdef ADC733_FB_FRAME_CNT_EN
    logic [7:0]  frame;
`endif
    logic [2:0]  ch;
    logic [15:0] data;
  } entry_t;

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);

  function automatic logic [2:0] ch_inc(input logic [2:0] c);
    return (c == 3'(NUM_CH-1)) ? 3'd0 : c + 3'd1;
  endfunction

  state_t      state, state_nxt;
  logic [2:0]  ch_cnt, ch_cnt_nxt;
  logic        accept, ferr_set;
  logic [2:0]  wr_ch;

  entry_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] level_nxt;
  logic        do_pop, do_wr, ovr_set;
  entry_t      wr_entry;

  // ---------------- alignment FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= UNSYNC;
      ch_cnt <= 3'd0;
    end else begin
      state  <= state_nxt;
      ch_cnt <= ch_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (word_valid) begin
      case (state)
        UNSYNC:  if (frame_start) state_nxt = SYNC;
        // A word arriving without a marker when a new frame is due means that
        // alignment is lost.
        SYNC:    if (!frame_start && ch_cnt == 3'd0) state_nxt = UNSYNC;
        default: state_nxt = UNSYNC;
      endcase
    end
  end

  always_comb begin
    accept     = 1'b0;
    ferr_set   = 1'b0;
    wr_ch      = ch_cnt;
    ch_cnt_nxt = ch_cnt;
    if (word_valid) begin
      case (state)
        UNSYNC: begin
          if (frame_start) begin
            accept     = 1'b1;
            wr_ch      = 3'd0;
            ch_cnt_nxt = ch_inc(3'd0);
          end
        end
        SYNC: begin
          if (frame_start) begin
            // A marker in mid-frame indicates a short frame. Realign on this word.
            accept     = 1'b1;
            ferr_set   = (ch_cnt != 3'd0);
            wr_ch      = 3'd0;
            ch_cnt_nxt = ch_inc(3'd0);
          end else if (ch_cnt != 3'd0) begin
            accept     = 1'b1;
            wr_ch      = ch_cnt;
            ch_cnt_nxt = ch_inc(ch_cnt);
          end else begin
            ferr_set   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- optional frame counter ----------------
`ifdef ADC733_FB_FRAME_CNT_EN
  logic [7:0] frame_cnt, frame_cnt_nxt;

  always_comb begin
    frame_cnt_nxt = frame_cnt;
    if (accept && wr_ch == 3'd0) frame_cnt_nxt = frame_cnt + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_cnt <= 8'd0;
    else     frame_cnt <= frame_cnt_nxt;
  end
`endif

  // ---------------- FIFO ----------------
  // When the FIFO is full, a pop in the same cycle frees the slot that the
  // write needs.
  assign do_pop  = rd_en && !empty;
  assign do_wr   = accept && (!full || do_pop);
  assign ovr_set = accept && full && !do_pop;

  always_comb begin
    wr_entry      = '0;
    wr_entry.ch   = wr_ch;
    wr_entry.data = word_data;
`ifdef ADC733_FB_FRAME_CNT_EN
    wr_entry.frame = frame_cnt_nxt;
`endif
  end

  always_comb begin
    level_nxt = level;
    if (do_wr && !do_pop)      level_nxt = level + LVL_ONE;
    else if (!do_wr && do_pop) level_nxt = level - LVL_ONE;
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_wr)  wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
      empty <= (level_nxt == '0);
      full  <= (level_nxt == LVL_FULL);
    end
  end

  // The read port is registered. When the FIFO is full, wr_ptr equals rd_ptr,
  // and the same-edge write cannot disturb the entry being popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_ch    <= '0;
`ifdef ADC733_FB_FRAME_CNT_EN
      rd_frame <= '0;
`endif
    end else begin
      rd_valid <= do_pop;
      if (do_pop) begin
        rd_data  <= mem[rd_ptr].data;
        rd_ch    <= mem[rd_ptr].ch;
`ifdef ADC733_FB_FRAME_CNT_EN
        rd_frame <= mem[rd_ptr].frame;
`endif
      end
    end
  end

  // ---------------- sticky flags ----------------
  // A new error in the same cycle as clr_err takes priority over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= ovr_set  | (overrun   & ~clr_err);
      frame_err <= ferr_set | (frame_err & ~clr_err);
    end
  end

endmodule

// File: tb/tb_adc733_frame_buffer.sv
module tb_adc733_frame_buffer;
  localparam int NUM_CH = 6;
  localparam int DEPTH  = 16;
  localparam int AW     = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        rst;
  logic        word_valid, frame_start, rd_en, clr_err;
  logic [15:0] word_data;
  logic [15:0] rd_data;
  logic [2:0]  rd_ch;
  logic [7:0]  rd_frame;
  logic        rd_valid, empty, full, overrun, frame_err;
  logic [AW:0] level;

  adc733_frame_buffer #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .word_valid(word_valid), .word_data(word_data),
    .frame_start(frame_start), .rd_en(rd_en), .rd_data(rd_data), .rd_ch(rd_ch),
`ifdef ADC733_FB_FRAME_CNT_EN
    .rd_frame(rd_frame),
`endif
    .rd_valid(rd_valid), .empty(empty), .full(full), .level(level),
    .overrun(overrun), .frame_err(frame_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of tagged samples plus the expected next channel
  // position within the frame (-1 while unaligned).
  typedef struct {
    logic [15:0] data;
    int          ch;
    int          frame;
  } ent_t;

  ent_t        q[$];
  int          pos;
  int          fcnt;
  bit          m_vld, m_ovr, m_fe;
  logic [15:0] m_data;
  int          m_ch, m_frame;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pos = -1; fcnt = 0;
    m_vld = 0; m_ovr = 0; m_fe = 0; m_data = 0; m_ch = 0; m_frame = 0;
  endtask

  task automatic chk_all();
    chk("level",     32'(level),     32'(q.size()));
    chk("empty",     32'(empty),     32'(q.size() == 0));
    chk("full",      32'(full),      32'(q.size() == DEPTH));
    chk("rd_valid",  32'(rd_valid),  32'(m_vld));
    chk("rd_data",   32'(rd_data),   32'(m_data));
    chk("rd_ch",     32'(rd_ch),     32'(m_ch));
    chk("overrun",   32'(overrun),   32'(m_ovr));
    chk("frame_err", 32'(frame_err), 32'(m_fe));
`ifdef ADC733_FB_FRAME_CNT_EN
    chk("rd_frame",  32'(rd_frame),  32'(m_frame));
`endif
  endtask

  // This task is called at a negedge. It drives one cycle of inputs, updates
  // the model, and then checks every output at the following negedge.
  task automatic step(input bit wv, input logic [15:0] wd, input bit fs,
                      input bit re, input bit clr);
    bit pop, acc, fe_set, ov_set;
    int ch;
    ent_t e;
    word_valid = wv; word_data = wd; frame_start = fs; rd_en = re; clr_err = clr;
    pop = re && (q.size() != 0);
    acc = 0; fe_set = 0; ov_set = 0; ch = 0;
    if (wv) begin
      if (fs) begin
        acc = 1; ch = 0;
        if (pos > 0) fe_set = 1;
        pos = 1 % NUM_CH;
      end else if (pos > 0) begin
        acc = 1; ch = pos;
        pos = (pos + 1) % NUM_CH;
      end else if (pos == 0) begin
        fe_set = 1; pos = -1;
      end
    end
    if (acc && ch == 0) fcnt = (fcnt + 1) % 256;
    m_vld = pop;
    if (pop) begin
      e = q.pop_front();
      m_data = e.data; m_ch = e.ch; m_frame = e.frame;
    end
    if (acc) begin
      if (q.size() < DEPTH) begin
        e.data = wd; e.ch = ch; e.frame = fcnt;
        q.push_back(e);
      end else ov_set = 1;
    end
    m_ovr = ov_set | (m_ovr & !clr);
    m_fe  = fe_set | (m_fe & !clr);
    @(posedge clk);
    @(negedge clk);
    word_valid = 0; frame_start = 0; rd_en = 0; clr_err = 0;
    chk_all();
  endtask

  initial begin
    int gpos;
    bit wv, fs, re;
    rst = 1; word_valid = 0; word_data = 0; frame_start = 0; rd_en = 0; clr_err = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk_all();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    rst = 0;
    @(negedge clk);

    // Words sent before a frame marker are discarded silently.
    for (int i = 0; i < 3; i++) step(1, 16'h0100 + 16'(i), 0, 0, 0);
    chk("unsync_level", 32'(level), 32'd0);
    chk("unsync_ferr",  32'(frame_err), 32'd0);

    // Send one aligned frame, then read it back.
    for (int i = 0; i < NUM_CH; i++) step(1, 16'h1111 * 16'(i + 1), i == 0, 0, 0);
    for (int i = 0; i < NUM_CH; i++) begin
      step(0, 0, 0, 1, 0);
      chk("frm_vld", 32'(rd_valid), 32'd1);
      chk("frm_ch",  32'(rd_ch),    32'(i));
      chk("frm_dat", 32'(rd_data),  32'(16'h1111 * 16'(i + 1)));
    end
    step(0, 0, 0, 0, 0);
    chk("frm_vld_off", 32'(rd_valid), 32'd0);
    chk("frm_empty",   32'(empty),    32'd1);

    // Send 17 words into a 16-entry FIFO with no reads.
    for (int i = 0; i < 17; i++) step(1, 16'hA000 + 16'(i), (i % NUM_CH) == 0, 0, 0);
    chk("ovf_full",  32'(full),    32'd1);
    chk("ovf_level", 32'(level),   32'd16);
    chk("ovf_ovr",   32'(overrun), 32'd1);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 1, 0);
      chk("ovf_dat", 32'(rd_data), 32'(16'hA000 + 16'(i)));
    end
    step(0, 0, 0, 0, 1);
    chk("ovf_clr", 32'(overrun), 32'd0);
    step(1, 16'h5555, 0, 0, 0);   // completes the frame (ch5)
    step(0, 0, 0, 1, 0);
    chk("ch5", 32'(rd_ch), 32'd5);

    // Short frame: four words, then a marker.
    for (int i = 0; i < 4; i++) step(1, 16'hC000 + 16'(i), i == 0, 0, 0);
    step(1, 16'hBEEF, 1, 0, 0);
    chk("short_ferr", 32'(frame_err), 32'd1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
    chk("short_ch0", 32'(rd_ch),   32'd0);
    chk("short_dat", 32'(rd_data), 32'hBEEF);
    step(0, 0, 0, 0, 1);
    chk("short_clr", 32'(frame_err), 32'd0);
    // Long frame: the rest of the frame, then a seventh word with no marker.
    for (int i = 1; i < NUM_CH; i++) step(1, 16'hD000 + 16'(i), 0, 0, 0);
    step(1, 16'hDEAD, 0, 0, 0);
    chk("long_ferr",  32'(frame_err), 32'd1);
    chk("long_level", 32'(level),     32'd5);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
    step(1, 16'h0BAD, 0, 0, 0);   // unaligned again, so this word is dropped
    chk("long_drop", 32'(level), 32'd0);
    step(0, 0, 0, 0, 1);

    // A write and a pop in the same cycle while the FIFO is full.
    for (int i = 0; i < 16; i++) step(1, 16'hE000 + 16'(i), (i % NUM_CH) == 0, 0, 0);
    chk("sim_full", 32'(level), 32'd16);
    step(1, 16'h7777, 0, 1, 0);
    chk("sim_level", 32'(level),   32'd16);
    chk("sim_ovr",   32'(overrun), 32'd0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 0);
    chk("sim_last", 32'(rd_data), 32'h7777);
    step(0, 0, 0, 1, 0);
    chk("empty_pop_vld", 32'(rd_valid), 32'd0);
    chk("empty_pop_lvl", 32'(level),    32'd0);

    // Randomized traffic. Markers mostly align, with occasional misplacements,
    // and the read rate alternates between low and high.
    gpos = 0;
    for (int i = 0; i < 600; i++) begin
      wv = ($urandom % 3) != 0;
      fs = wv && ((gpos == 0) ^ (($urandom % 20) == 0));
      if (wv) gpos = fs ? 1 % NUM_CH : (gpos + 1) % NUM_CH;
      re = ($urandom % 100) < (((i / 100) % 2) ? 75 : 30);
      step(wv, 16'($urandom), fs, re, ($urandom % 16) == 0);
    end

    // Asynchronous reset asserted mid-cycle while data is buffered.
    for (int i = 0; i < 5; i++) step(1, 16'hF000 + 16'(i), i == 0, i == 3, 0);
    #2 rst = 1;
    #1;
    model_reset();
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_vld",   32'(rd_valid), 32'd0);
`ifdef ADC733_FB_FRAME_CNT_EN
    chk("arst_frame", 32'(rd_frame), 32'd0);
`endif
    @(negedge clk);
    rst = 0;
    chk_all();

`ifdef ADC733_FB_FRAME_CNT_EN
    for (int i = 0; i < 3 * NUM_CH; i++) begin
      step(1, 16'(i), (i % NUM_CH) == 0, 0, 0);
      if (i == 15) step(0, 0, 0, 1, 0);
    end
    for (int i = 1; i < 3 * NUM_CH; i++) begin
      step(0, 0, 0, 1, 0);
      chk("fcnt", 32'(rd_frame), 32'(1 + i / NUM_CH));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog: the directed sequence is bounded, so this fires only if the run stalls.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/adc733_frame_buffer.md
Name: adc733_frame_buffer

Overview:
- Downstream consumer of the adc733 serial interface; sits in the clk domain after the captured-word synchroniser.
- Accepts 16-bit ADC words as single-cycle strobes and checks frame alignment using a frame-start marker.
- Tags each word with its channel index and buffers it in a synchronous FIFO for the readout/DSP logic.
- Reports overrun and framing errors as sticky flags.

Parameters:
- NUM_CH, 6, channels per ADC frame (2..8).
- DEPTH, 16, FIFO entries; power of 2, 4..256.
- AW, $clog2(DEPTH), FIFO address width (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- word_valid  in  1  one-cycle strobe: word_data holds a new sample.
- word_data  in  16  sample word.
- frame_start  in  1  qualifies word_valid; marks the word as channel 0 of a frame.
- rd_en  in  1  pop request.
- rd_data  out  16  popped sample; registered.
- rd_ch  out  3  channel index of the popped sample.
- rd_valid  out  1  rd_data/rd_ch are valid this cycle.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- level  out  AW+1  current occupancy, 0..DEPTH.
- overrun  out  1  sticky: an accepted word was dropped because the FIFO was full.
- frame_err  out  1  sticky: alignment violation.
- clr_err  in  1  synchronous clear of overrun and frame_err.

Behaviour:
- Reset (async, rst=1):
  - State UNSYNC; channel counter 0; FIFO pointers and level 0.
  - empty=1, full=0, rd_valid=0, rd_data=0, rd_ch=0, overrun=0, frame_err=0.
  - Reset asserted mid-operation discards all buffered data immediately.
- FSM, two states:
  - UNSYNC: word_valid without frame_start is dropped silently. word_valid with frame_start is accepted as channel 0; counter goes to 1 (or 0 if NUM_CH would wrap); next state SYNC.
  - SYNC, word_valid with frame_start:
    - counter==0: accept as ch0; counter goes to 1.
    - counter!=0 (short frame): set frame_err; accept the word as ch0; counter goes to 1; stay in SYNC (realign).
  - SYNC, word_valid without frame_start:
    - counter!=0: accept with channel=counter; counter increments and wraps to 0 after NUM_CH-1.
    - counter==0 (long frame / missing marker): set frame_err; drop the word; go to UNSYNC.
  - frame_start without word_valid is ignored.
- Write side, for each accepted word:
  - If not full, or if full and a valid pop occurs in the same cycle: write {ch, data}.
  - Otherwise drop the word and set overrun.
  - Dropped words still advance the channel counter.
- Read side:
  - rd_en with empty=0: pop; rd_data/rd_ch update and rd_valid=1 on the next cycle (latency 1).
  - rd_en with empty=1: ignored; rd_valid=0; pointers unchanged.
  - rd_valid is 0 in any cycle following no pop; rd_data holds its last value.
- Level and flags:
  - level: +1 on write only, -1 on pop only, unchanged on simultaneous write and pop.
  - full = (level==DEPTH); empty = (level==0). Both are registered and consistent with level.
  - Simultaneous write and pop while empty: the pop is ignored and the write lands.
  - Pointers wrap modulo DEPTH.
- Sticky flags:
  - clr_err=1 clears overrun and frame_err next cycle.
  - A new error in the same cycle as clr_err wins (flag stays 1).

Optional Feature:
ADC733_FB_FRAME_CNT_EN
- Defined:
  - An 8-bit frame counter increments (wrapping 255->0) on every accepted ch0 word.
  - The counter is stored with each FIFO entry.
  - An extra output port rd_frame [7:0] returns it alongside rd_data; reset value 0.
- Undefined: no counter, no rd_frame port, FIFO entry width 19 bits.

Test Plan:
- Reset, then feed 3 words without frame_start -> all dropped; level=0; frame_err=0.
- frame_start+0x1111, then 0x2222..0x6666 (NUM_CH=6), then pop 6 -> rd_ch 0..5 in order; rd_data 0x1111..0x6666; rd_valid exactly 1 cycle after each rd_en; empty=1 after.
- Push 17 words with DEPTH=16 and no reads -> full=1, level=16, overrun=1; the 17th word is absent from the readout. clr_err -> overrun=0.
- Frame of 4 words, then frame_start -> frame_err=1; the new word reads back as ch0. A 7th word without frame_start after a complete frame -> frame_err, state UNSYNC, the word is not stored.
- At level=16, word_valid and rd_en in the same cycle -> level stays 16; overrun stays 0; the word is stored. rd_en at empty -> rd_valid=0, level=0.
- With ADC733_FB_FRAME_CNT_EN: 3 frames -> rd_frame reads 1,1..,2..,3 per frame; rst mid-frame -> empty=1, rd_frame=0.
